// File: rtl/fetcher.sv
// Instruction fetch unit: one program-memory read per FETCH phase, word held for decode.
// Request issues on the edge that samples FETCH; capture on the first edge with ready high.
package gpu_pkg;
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;
endpackage

module fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  core_state_t                      core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [1:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [7:0]                       fetch_wait_cycles
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_FETCHING = 2'b01,
    S_FETCHED  = 2'b10
  } fetch_state_t;

  fetch_state_t                     r_state;
  logic                             r_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
  logic [7:0]                       r_wait;

  fetch_state_t                     w_state_nx;
  logic                             w_valid_nx;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] w_addr_nx;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_instr_nx;
  logic [7:0]                       w_wait_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_valid <= w_valid_nx;
      r_addr  <= w_addr_nx;
      r_instr <= w_instr_nx;
      r_wait  <= w_wait_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_valid;
    w_addr_nx  = r_addr;
    w_instr_nx = r_instr;
    w_wait_nx  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (core_state == CORE_FETCH) begin
          w_valid_nx = 1'b1;
          w_addr_nx  = current_pc;
          w_wait_nx  = 8'd0;
          w_state_nx = S_FETCHING;
        end
      end
      S_FETCHING: begin
        // Address and core_state are deliberately not looked at here: the request is frozen.
        if (mem_read_ready) begin
          w_instr_nx = mem_read_data;
          w_valid_nx = 1'b0;
          w_state_nx = S_FETCHED;
        end else if (r_wait != 8'hFF) begin
          w_wait_nx = r_wait + 8'd1;
        end
      end
      S_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  assign mem_read_valid    = r_valid;
  assign mem_read_address  = r_addr;
  assign fetcher_state     = r_state;
  assign instruction       = r_instr;
  assign fetch_wait_cycles = r_wait;

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher: transaction-level expectations per fetch (address, word, clipped wait count).
module tb_fetcher;
  import gpu_pkg::*;

  logic        clk;
  logic        rst_n;
  core_state_t core_state;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [1:0]  fetcher_state;
  logic [15:0] instruction;
  logic [7:0]  fetch_wait_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: last word actually delivered by a completed fetch, and last issued address.
  logic [15:0] m_instr;
  logic [7:0]  m_addr;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_FETCHING = 2'b01, ST_FETCHED = 2'b10;

  fetcher dut (
    .clk(clk), .rst_n(rst_n), .core_state(core_state), .current_pc(current_pc),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction),
    .fetch_wait_cycles(fetch_wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] clip_wait(input int n);
    int c;
    c = (n > 255) ? 255 : n;
    return c[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch: issue, nwait stalled cycles, capture, nhold cycles parked in FETCHED, DECODE.
  task automatic run_fetch(input logic [7:0] pc, input logic [15:0] data, input int nwait,
                           input int nhold, input string name);
    core_state     = CORE_FETCH;
    current_pc     = pc;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'($urandom);
    step();
    m_addr = pc;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !==
        {ST_FETCHING, 1'b1, m_addr, 8'd0, m_instr}) begin
      n_errors++;
      $display("FAIL %s issue: st=%b vld=%b adr=%h wt=%0d ins=%h want st=01 vld=1 adr=%h wt=0 ins=%h",
               name, fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles,
               instruction, m_addr, m_instr);
    end
    for (int i = 1; i <= nwait; i++) begin
      current_pc    = 8'($urandom);
      core_state    = core_state_t'($urandom_range(0, 7));
      mem_read_data = 16'($urandom);
      step();
      n_checks++;
      if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !==
          {ST_FETCHING, 1'b1, m_addr, clip_wait(i), m_instr}) begin
        n_errors++;
        $display("FAIL %s wait%0d: st=%b vld=%b adr=%h wt=%0d ins=%h want st=01 vld=1 adr=%h wt=%0d ins=%h",
                 name, i, fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles,
                 instruction, m_addr, clip_wait(i), m_instr);
      end
    end
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    current_pc     = 8'($urandom);
    step();
    m_instr = data;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !==
        {ST_FETCHED, 1'b0, m_addr, clip_wait(nwait), m_instr}) begin
      n_errors++;
      $display("FAIL %s capture: st=%b vld=%b adr=%h wt=%0d ins=%h want st=10 vld=0 adr=%h wt=%0d ins=%h",
               name, fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles,
               instruction, m_addr, clip_wait(nwait), m_instr);
    end
    for (int h = 0; h < nhold; h++) begin
      core_state     = ($urandom_range(0, 1) == 0) ? CORE_FETCH : CORE_EXECUTE;
      mem_read_ready = 1'($urandom);
      mem_read_data  = 16'($urandom);
      current_pc     = 8'($urandom);
      step();
      n_checks++;
      if ({fetcher_state, mem_read_valid, fetch_wait_cycles, instruction} !==
          {ST_FETCHED, 1'b0, clip_wait(nwait), m_instr}) begin
        n_errors++;
        $display("FAIL %s hold%0d: st=%b vld=%b wt=%0d ins=%h want st=10 vld=0 wt=%0d ins=%h",
                 name, h, fetcher_state, mem_read_valid, fetch_wait_cycles, instruction,
                 clip_wait(nwait), m_instr);
      end
    end
    core_state     = CORE_DECODE;
    mem_read_ready = 1'($urandom);
    step();
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !==
        {ST_IDLE, 1'b0, m_addr, clip_wait(nwait), m_instr}) begin
      n_errors++;
      $display("FAIL %s decode: st=%b vld=%b adr=%h wt=%0d ins=%h want st=00 vld=0 adr=%h wt=%0d ins=%h",
               name, fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles,
               instruction, m_addr, clip_wait(nwait), m_instr);
    end
    core_state     = CORE_IDLE;
    mem_read_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    core_state     = CORE_IDLE;
    current_pc     = 8'h3C;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hFFFF;
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    m_instr = 16'h0;
    m_addr  = 8'h0;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset: st=%b vld=%b adr=%h wt=%0d ins=%h want all zero",
               fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction);
    end
    for (int i = 0; i < 5; i++) begin
      mem_read_ready = 1'($urandom);
      step();
      n_checks++;
      if ({fetcher_state, mem_read_valid, instruction} !== {ST_IDLE, 1'b0, 16'h0}) begin
        n_errors++;
        $display("FAIL idle_quiet%0d: st=%b vld=%b ins=%h want st=00 vld=0 ins=0000",
                 i, fetcher_state, mem_read_valid, instruction);
      end
    end
    mem_read_ready = 1'b0;
  endtask

  task automatic test_min_latency();
    int vld_cycles;
    core_state     = CORE_FETCH;
    current_pc     = 8'h05;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hA1B2;
    vld_cycles     = 0;
    step();
    if (mem_read_valid) vld_cycles++;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address} !== {ST_FETCHING, 1'b1, 8'h05}) begin
      n_errors++;
      $display("FAIL minlat_issue: st=%b vld=%b adr=%h want st=01 vld=1 adr=05",
               fetcher_state, mem_read_valid, mem_read_address);
    end
    step();
    if (mem_read_valid) vld_cycles++;
    m_instr = 16'hA1B2;
    m_addr  = 8'h05;
    n_checks++;
    if ({fetcher_state, instruction, fetch_wait_cycles} !== {ST_FETCHED, 16'hA1B2, 8'd0}) begin
      n_errors++;
      $display("FAIL minlat_capture: st=%b ins=%h wt=%0d want st=10 ins=a1b2 wt=0",
               fetcher_state, instruction, fetch_wait_cycles);
    end
    core_state = CORE_DECODE;
    step();
    if (mem_read_valid) vld_cycles++;
    n_checks++;
    if (vld_cycles !== 1) begin
      n_errors++;
      $display("FAIL minlat_vld_width: got %0d cycles want 1", vld_cycles);
    end
    n_checks++;
    if ({fetcher_state, instruction} !== {ST_IDLE, 16'hA1B2}) begin
      n_errors++;
      $display("FAIL minlat_decode: st=%b ins=%h want st=00 ins=a1b2", fetcher_state, instruction);
    end
    core_state     = CORE_IDLE;
    mem_read_ready = 1'b0;
  endtask

  task automatic test_wait_count();
    run_fetch(8'h10, 16'h5A5A, 4, 1, "wait4");
  endtask

  task automatic test_saturation();
    run_fetch(8'($urandom), 16'($urandom), 300, 2, "sat300");
  endtask

  task automatic test_async_reset();
    core_state     = CORE_FETCH;
    current_pc     = 8'h33;
    mem_read_ready = 1'b0;
    step();
    core_state = CORE_IDLE;
    step();
    #2 rst_n = 1'b0;
    #1;
    m_instr = 16'h0;
    m_addr  = 8'h0;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction} !== 35'd0) begin
      n_errors++;
      $display("FAIL async_reset: st=%b vld=%b adr=%h wt=%0d ins=%h want all zero",
               fetcher_state, mem_read_valid, mem_read_address, fetch_wait_cycles, instruction);
    end
    step();
    #2 rst_n = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    step();
    step();
    mem_read_ready = 1'b0;
    n_checks++;
    if ({fetcher_state, mem_read_valid, instruction} !== {ST_IDLE, 1'b0, 16'h0}) begin
      n_errors++;
      $display("FAIL late_ready: st=%b vld=%b ins=%h want st=00 vld=0 ins=0000",
               fetcher_state, mem_read_valid, instruction);
    end
  endtask

  task automatic test_back_to_back();
    run_fetch(8'h00, 16'h1111, $urandom_range(0, 3), 3, "b2b_first");
    run_fetch(8'h01, 16'h2222, $urandom_range(1, 3), 2, "b2b_second");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      run_fetch(8'($urandom), 16'($urandom), $urandom_range(0, 10), $urandom_range(0, 3), "rand");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    m_instr = 16'h0;
    m_addr  = 8'h0;
    test_reset();
    test_min_latency();
    test_wait_count();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
